// File: rtl/display_arbiter.sv
// display_arbiter: picks the 32-bit word shown on the 8-digit hex display.
// The base word is shown by default. Two requesters get timed overlays with
// fixed priority (requester 1 over requester 0), and per-digit blinking can
// mark edit cursors.
//
// Optional feature: define DISPLAY_BLINK_EN to build in the blink logic.
// Without it, blink_mask is ignored and data_out is the selected word,
// registered.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   base_data     default display word
//   req[1:0]      overlay request pulses, one bit per requester
//   ovl0_data     overlay word for requester 0 (live, not latched)
//   ovl1_data     overlay word for requester 1 (live, not latched)
//   blink_mask    bit i blinks nibble i of the selected word
//   data_out      registered word to the display driver
//   grant         one-hot display owner, 2'b00 = base
//   pending       requester 0 is waiting behind requester 1
module display_arbiter #(
    parameter int unsigned CLK_FREQ_HZ = 1000,
    parameter int unsigned HOLD_MS     = 2000,
    parameter int unsigned BLINK_HZ    = 2,
    parameter logic [3:0]  BLANK_VAL   = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] base_data,
    input  logic [1:0]  req,
    input  logic [31:0] ovl0_data,
    input  logic [31:0] ovl1_data,
    input  logic [7:0]  blink_mask,
    output logic [31:0] data_out,
    output logic [1:0]  grant,
    output logic        pending
);

    localparam int unsigned DIV = CLK_FREQ_HZ / 1000;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HW  = 16;

    typedef enum logic [1:0] {
        BASE  = 2'b00,
        SHOW0 = 2'b01,
        SHOW1 = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic            pending_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic [PW-1:0]   pre_cnt;
    logic            tick_c;
    logic            expire_c;
    logic            load_c;
    logic [31:0]     sel_c;

    // 1 ms tick prescaler
    assign tick_c = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick_c) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Hold expires on the first tick seen after it has counted down to 0,
    // so an overlay lasts HOLD_MS..HOLD_MS+1 ms after the last pulse.
    assign expire_c = tick_c && (hold == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BASE;
            pending <= 1'b0;
            hold    <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            hold    <= hold_nxt;
        end
    end

    // Next-state logic: same-requester retrigger beats expiry
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        load_c      = 1'b0;
        case (state)
            BASE: begin
                if (req[1]) begin
                    state_nxt   = SHOW1;
                    pending_nxt = req[0];
                    load_c      = 1'b1;
                end else if (req[0]) begin
                    state_nxt = SHOW0;
                    load_c    = 1'b1;
                end
            end
            SHOW0: begin
                if (req[1]) begin
                    state_nxt   = SHOW1;
                    pending_nxt = 1'b1;
                    load_c      = 1'b1;
                end else if (req[0]) begin
                    load_c = 1'b1;
                end else if (expire_c) begin
                    state_nxt = BASE;
                end
            end
            SHOW1: begin
                if (req[1]) begin
                    load_c = 1'b1;
                    if (req[0]) begin
                        pending_nxt = 1'b1;
                    end
                end else if (expire_c) begin
                    // A req[0] on the expiry cycle counts as pending.
                    if (pending || req[0]) begin
                        state_nxt   = SHOW0;
                        pending_nxt = 1'b0;
                        load_c      = 1'b1;
                    end else begin
                        state_nxt = BASE;
                    end
                end else if (req[0]) begin
                    pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = BASE;
                pending_nxt = 1'b0;
            end
        endcase

        hold_nxt = hold;
        if (load_c) begin
            hold_nxt = HW'(HOLD_MS);
        end else if (tick_c && (hold != '0)) begin
            hold_nxt = hold - HW'(1);
        end
    end

    assign grant = state;

    // Word select follows the owner being granted this edge
    always_comb begin
        case (state_nxt)
            SHOW0:   sel_c = ovl0_data;
            SHOW1:   sel_c = ovl1_data;
            default: sel_c = base_data;
        endcase
    end

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned HALF = 1000 / (2 * BLINK_HZ);
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          vis, vis_nxt;
    logic [31:0]   word_c;

    // Blink phase; any grant change restarts in the visible phase
    always_comb begin
        blink_cnt_nxt = blink_cnt;
        vis_nxt       = vis;
        if (state_nxt != state) begin
            blink_cnt_nxt = '0;
            vis_nxt       = 1'b1;
        end else if (tick_c) begin
            if (blink_cnt == BW'(HALF - 1)) begin
                blink_cnt_nxt = '0;
                vis_nxt       = ~vis;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            vis       <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            vis       <= vis_nxt;
        end
    end

    // Blank masked nibbles in the off phase
    always_comb begin
        word_c = sel_c;
        for (int i = 0; i < 8; i++) begin
            if (blink_mask[i] && !vis_nxt) begin
                word_c[4*i +: 4] = BLANK_VAL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= word_c;
        end
    end
`else
    localparam int unsigned UNUSED_BLINK = BLINK_HZ + 32'(BLANK_VAL);

    logic unused_mask;
    assign unused_mask = ^{blink_mask, UNUSED_BLINK[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= sel_c;
        end
    end
`endif

endmodule
